// File: rtl/dfi_wr_datapath.sv
// DFI write-data path: queues issued write commands, times each burst by its
// sampled write latency and streams write-buffer beats onto the DFI data bus.
module dfi_wr_datapath #(
  parameter  int DQ_WIDTH  = 32,
  parameter  int MAX_WL    = 15,
  parameter  int CMD_DEPTH = 4,
  localparam int WL_W      = $clog2(MAX_WL + 1),
  localparam int DW        = 2 * DQ_WIDTH,
  localparam int MW        = DW / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WL_W-1:0] cfg_t_wl,
  input  logic            cfg_bl8,
  input  logic            wr_issue,
  output logic            cmd_full,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [DW-1:0]   wdata,
  input  logic [MW-1:0]   wstrb,
  output logic            dfi_wrdata_en,
  output logic [DW-1:0]   dfi_wrdata,
  output logic [MW-1:0]   dfi_wrdata_mask,
  output logic            busy,
  output logic            err_underflow,
  output logic            err_overflow,
  input  logic            err_clr
);

  localparam int CW = $clog2(CMD_DEPTH + 1);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e          state_q, state_d;
  logic [1:0]      rem_q, rem_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WL_W-1:0] cnt_q [CMD_DEPTH];
  logic [WL_W-1:0] cnt_d [CMD_DEPTH];
  logic            bl8_q [CMD_DEPTH];
  logic            bl8_d [CMD_DEPTH];
  logic            en_q, en_d;
  logic [DW-1:0]   data_q, data_d;
  logic [MW-1:0]   mask_q, mask_d;
  logic            uf_q, uf_d;
  logic            of_q, of_d;

  logic [WL_W-1:0] wl_eff;
  logic            head_due;
  logic            start;
  logic            beat_needed;
  logic            push_ok;
  logic [CW-1:0]   wr_idx;

  // Entry counters are loaded with wl-1 so the first beat lands exactly wl edges after issue.
  always_comb begin
    wl_eff = cfg_t_wl;
    if (cfg_t_wl == '0) begin
      wl_eff = WL_W'(1);
    end else if (int'(cfg_t_wl) > MAX_WL) begin
      wl_eff = WL_W'(MAX_WL);
    end
  end

  assign head_due    = (count_q != '0) && (cnt_q[0] == '0);
  assign start       = head_due && ((state_q == S_IDLE) || (rem_q == 2'd0));
  assign beat_needed = start || ((state_q == S_BURST) && (rem_q != 2'd0));
  assign push_ok     = wr_issue && ((count_q != CW'(CMD_DEPTH)) || start);
  assign wr_idx      = count_q - CW'(start);

  // Shift-register queue: entry 0 is the head; a pop shifts everything down one slot.
  always_comb begin
    for (int i = 0; i < CMD_DEPTH; i++) begin
      cnt_d[i] = (cnt_q[(start && (i < CMD_DEPTH - 1)) ? i + 1 : i] == '0) ? '0 :
                 cnt_q[(start && (i < CMD_DEPTH - 1)) ? i + 1 : i] - WL_W'(1);
      bl8_d[i] = bl8_q[(start && (i < CMD_DEPTH - 1)) ? i + 1 : i];
      if (push_ok && (wr_idx == CW'(i))) begin
        cnt_d[i] = wl_eff - WL_W'(1);
        bl8_d[i] = cfg_bl8;
      end
    end
    count_d = count_q - CW'(start) + CW'(push_ok);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = '0;
    mask_d  = '0;
    if (start) begin
      state_d = S_BURST;
      rem_d   = bl8_q[0] ? 2'd3 : 2'd1;
    end else if (state_q == S_BURST) begin
      if (rem_q != 2'd0) begin
        rem_d = rem_q - 2'd1;
      end else begin
        state_d = S_IDLE;
      end
    end
    en_d = beat_needed;
    if (beat_needed) begin
      data_d = wdata_valid ? wdata : '0;
      mask_d = wdata_valid ? ~wstrb : '1;
    end
    uf_d = (uf_q && !err_clr) || (beat_needed && !wdata_valid);
    of_d = (of_q && !err_clr) || (wr_issue && !push_ok);
  end

  // NOTE: the command queue is a handful of flops, so it is reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 2'd0;
      count_q <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cnt_q[i] <= '0;
        bl8_q[i] <= 1'b0;
      end
      en_q    <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
        bl8_q[i] <= bl8_d[i];
      end
      en_q    <= en_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  assign cmd_full        = (count_q == CW'(CMD_DEPTH));
  assign wdata_ready     = beat_needed;
  assign dfi_wrdata_en   = en_q;
  assign dfi_wrdata      = data_q;
  assign dfi_wrdata_mask = mask_q;
  assign busy            = (count_q != '0) || (state_q == S_BURST);
  assign err_underflow   = uf_q;
  assign err_overflow    = of_q;

endmodule

// File: tb/tb_dfi_wr_datapath.sv
// Bench for dfi_wr_datapath: latency table, directed corner sequences and random
// traffic against a slot-schedule reference model.
module tb_dfi_wr_datapath;

  localparam int DQ_WIDTH  = 32;
  localparam int MAX_WL    = 15;
  localparam int CMD_DEPTH = 4;
  localparam int DW        = 2 * DQ_WIDTH;
  localparam int MW        = DW / 8;
  localparam int NSLOT     = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cfg_t_wl;
  logic          cfg_bl8;
  logic          wr_issue;
  logic          cmd_full;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wstrb;
  logic          dfi_wrdata_en;
  logic [DW-1:0] dfi_wrdata;
  logic [MW-1:0] dfi_wrdata_mask;
  logic          busy;
  logic          err_underflow;
  logic          err_overflow;
  logic          err_clr;

  dfi_wr_datapath #(
    .DQ_WIDTH (DQ_WIDTH),
    .MAX_WL   (MAX_WL),
    .CMD_DEPTH(CMD_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_t_wl       (cfg_t_wl),
    .cfg_bl8        (cfg_bl8),
    .wr_issue       (wr_issue),
    .cmd_full       (cmd_full),
    .wdata_valid    (wdata_valid),
    .wdata_ready    (wdata_ready),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .dfi_wrdata_en  (dfi_wrdata_en),
    .dfi_wrdata     (dfi_wrdata),
    .dfi_wrdata_mask(dfi_wrdata_mask),
    .busy           (busy),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted command owns a run of beat slots on an absolute
  // timeline, starting at max(issue + wl, end of the previous burst).
  int          checks;
  int          failures;
  int          cyc;
  int          next_free;
  bit          slot [NSLOT];
  int          starts [$];
  bit          exp_uf;
  bit          exp_of;
  logic [31:0] en_hist;

  typedef struct {
    logic [3:0] wl;
    bit         bl8;
    int         exp_off;
    int         exp_len;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit slot_at(input int i);
    return (i >= 0 && i < NSLOT) ? slot[i] : 1'b0;
  endfunction

  function automatic int pending_after(input int c);
    int n = 0;
    foreach (starts[i]) if (starts[i] > c) n++;
    return n;
  endfunction

  task automatic clear_model();
    foreach (slot[i]) slot[i] = 1'b0;
    starts.delete();
    next_free = 0;
    exp_uf    = 1'b0;
    exp_of    = 1'b0;
    en_hist   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " en"},    dfi_wrdata_en, 1'b0);
    check({tag, " data"},  dfi_wrdata, '0);
    check({tag, " mask"},  dfi_wrdata_mask, '0);
    check({tag, " busy"},  busy, 1'b0);
    check({tag, " full"},  cmd_full, 1'b0);
    check({tag, " ready"}, wdata_ready, 1'b0);
    check({tag, " uf"},    err_underflow, 1'b0);
    check({tag, " of"},    err_overflow, 1'b0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    wr_issue    = 1'b0;
    err_clr     = 1'b0;
    wdata_valid = 1'b0;
    cfg_t_wl    = 4'd1;
    cfg_bl8     = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    #1;
    check_all_zero("reset");
    clear_model();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst = 1'b0;
  endtask

  task automatic step(input bit issue, input bit bl8, input logic [3:0] wl,
                      input bit valid, input bit clr, input bit full_strb);
    bit            ex_en;
    bit            of_set;
    logic [DW-1:0] ex_data;
    logic [MW-1:0] ex_mask;
    int            pend;
    int            wl_e;
    int            n;
    int            st;
    wr_issue    = issue;
    cfg_bl8     = bl8;
    cfg_t_wl    = wl;
    wdata_valid = valid;
    err_clr     = clr;
    wdata       = {$urandom, $urandom};
    wstrb       = full_strb ? '1 : MW'($urandom);
    #1;
    check("wdata_ready", wdata_ready, slot_at(cyc + 1));
    @(posedge clk);
    cyc++;
    of_set = 1'b0;
    if (issue) begin
      if (pending_after(cyc) < CMD_DEPTH) begin
        wl_e = (wl == 4'd0) ? 1 : int'(wl);
        if (wl_e > MAX_WL) wl_e = MAX_WL;
        n  = bl8 ? 4 : 2;
        st = cyc + wl_e;
        if (next_free > st) st = next_free;
        for (int k = 0; k < n; k++) if (st + k < NSLOT) slot[st + k] = 1'b1;
        next_free = st + n;
        starts.push_back(st);
      end else begin
        of_set = 1'b1;
      end
    end
    ex_en   = slot_at(cyc);
    ex_data = (ex_en && valid) ? wdata : '0;
    ex_mask = ex_en ? (valid ? ~wstrb : '1) : '0;
    exp_uf  = (exp_uf && !clr) || (ex_en && !valid);
    exp_of  = (exp_of && !clr) || of_set;
    pend    = pending_after(cyc);
    #1;
    check("dfi_wrdata_en",   dfi_wrdata_en, ex_en);
    check("dfi_wrdata",      dfi_wrdata, ex_data);
    check("dfi_wrdata_mask", dfi_wrdata_mask, ex_mask);
    check("busy",            busy, ex_en || (pend > 0));
    check("cmd_full",        cmd_full, pend == CMD_DEPTH);
    check("err_underflow",   err_underflow, exp_uf);
    check("err_overflow",    err_overflow, exp_of);
    en_hist = {en_hist[30:0], dfi_wrdata_en};
  endtask

  task automatic idle(input int n, input bit valid);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd1, valid, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int first;
    int len;
    int beats;
    checks   = 0;
    failures = 0;
    cyc      = 0;

    vecs[0] = '{wl: 4'd0,  bl8: 1'b0, exp_off: 1,  exp_len: 2};
    vecs[1] = '{wl: 4'd1,  bl8: 1'b1, exp_off: 1,  exp_len: 4};
    vecs[2] = '{wl: 4'd2,  bl8: 1'b0, exp_off: 2,  exp_len: 2};
    vecs[3] = '{wl: 4'd3,  bl8: 1'b1, exp_off: 3,  exp_len: 4};
    vecs[4] = '{wl: 4'd9,  bl8: 1'b1, exp_off: 9,  exp_len: 4};
    vecs[5] = '{wl: 4'd15, bl8: 1'b0, exp_off: 15, exp_len: 2};

    do_reset();

    // Single-command latency and burst length per table entry.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      first = -1;
      len   = 0;
      step(1'b1, vecs[v].bl8, vecs[v].wl, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k < 25; k++) begin
        step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        if (dfi_wrdata_en) begin
          if (first < 0) first = k;
          len++;
        end
      end
      check($sformatf("vec%0d first_beat", v), first, vecs[v].exp_off);
      check($sformatf("vec%0d burst_len", v), len, vecs[v].exp_len);
    end

    // t_wl=3 BL8 single burst: en on offsets 3..6, idle after.
    do_reset();
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    idle(7, 1'b1);
    check("t1 en_pattern", en_hist[7:0], 8'h1E);
    check("t1 busy_after", busy, 1'b0);

    // t_wl=2 BL4 issues two apart: contiguous 4 beats.
    do_reset();
    step(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    check("t2 en_pattern", en_hist[7:0], 8'h3C);
    check("t2 no_errors", {err_underflow, err_overflow}, 2'b00);

    // t_wl=2 BL8 back-to-back issues: second burst deferred, no gap.
    do_reset();
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
    idle(9, 1'b1);
    check("t3 en_pattern", en_hist[10:0], 11'b001_1111_1110);
    check("t3 no_errors", {err_underflow, err_overflow}, 2'b00);

    // BL8 with the third beat missing.
    do_reset();
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check("t4 hole_data", dfi_wrdata, 64'h0);
    check("t4 hole_mask", dfi_wrdata_mask, 8'hFF);
    check("t4 hole_en", dfi_wrdata_en, 1'b1);
    idle(3, 1'b1);
    check("t4 uf_sticky", err_underflow, 1'b1);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
    check("t4 uf_cleared", err_underflow, 1'b0);

    // Queue overflow: five issues at t_wl=15, four bursts survive.
    do_reset();
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
      if (i == 3) check("t5 full_after_4th", cmd_full, 1'b1);
    end
    check("t5 overflow", err_overflow, 1'b1);
    for (int i = 0; i < 35; i++) begin
      step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      if (dfi_wrdata_en) beats++;
    end
    check("t5 beat_count", beats, 16);
    check("t5 busy_after", busy, 1'b0);

    // Reset during beat 2 of a burst with two more commands queued.
    do_reset();
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    check("t6 pre_reset_en", dfi_wrdata_en, 1'b1);
    do_reset();
    idle(10, 1'b1);
    check("t6 en_after", en_hist[9:0], 10'h0);
    check("t6 busy_after", busy, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0),
           1'($urandom),
           ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0),
           1'b0);
    end
    idle(60, 1'b1);
    check("rand drained", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfi_wr_datapath.md
Name: dfi_wr_datapath

Overview:
Parametrised DFI write-data path for the DDR controller, the generalised successor of the fixed 64-bit write-data bundle.
- Accepts write-command issue pulses from the scheduler and queues them.
- Times each burst by a programmable write latency.
- Streams write data beats from the write buffer onto dfi_wrdata_en / dfi_wrdata / dfi_wrdata_mask.
- Supports per-command BL4/BL8 mode, configurable DQ width and multiple outstanding commands.
- Sits between the scheduler/write buffer and the DFI PHY.

Parameters:
DQ_WIDTH, 32, DRAM DQ width; each DFI beat carries 2*DQ_WIDTH bits (DDR, 1:1 clock ratio).
MAX_WL, 15, largest supported write latency in controller clocks; WL_W = clog2(MAX_WL+1).
CMD_DEPTH, 4, number of issued-but-not-started write commands held.

Ports:
clk  input  1  controller clock
rst  input  1  asynchronous reset, active-high
cfg_t_wl  input  WL_W  write latency; 0 treated as 1; values above MAX_WL saturate to MAX_WL
cfg_bl8  input  1  1: BL8 (4 DFI beats), 0: BL4 (2 DFI beats)
wr_issue  input  1  pulse: WR command driven on DFI control this cycle
cmd_full  output  1  command queue holds CMD_DEPTH entries
wdata_valid  input  1  write buffer beat valid
wdata_ready  output  1  beat consumed this cycle
wdata  input  2*DQ_WIDTH  write data beat
wstrb  input  2*DQ_WIDTH/8  byte enables (1 = write)
dfi_wrdata_en  output  1  DFI write data enable
dfi_wrdata  output  2*DQ_WIDTH  DFI write data
dfi_wrdata_mask  output  2*DQ_WIDTH/8  DFI byte mask (1 = masked)
busy  output  1  queue non-empty or burst in progress
err_underflow  output  1  sticky: required beat not available
err_overflow  output  1  sticky: issue while queue full
err_clr  input  1  clears both sticky errors

Behaviour:
- Reset (async assert): flush queue, idle burst engine. All outputs 0 (cmd_full, wdata_ready, dfi_*, busy, errors).
- All dfi_* outputs and errors are registered. wdata_ready is combinational; it is high in the cycle before the beat that consumes it.
- Issue path:
  - wr_issue sampled at edge T captures cfg_bl8 and the effective t_wl into a queue entry with a down-counter.
  - All entry counters decrement every cycle and saturate at 0.
  - Config is sampled per command, so changes affect only later issues.
- Latency: with the queue empty and engine idle, dfi_wrdata_en is high in the cycles starting at edge T+t_wl, for N cycles (N = 4 for BL8, 2 for BL4).
- Burst engine states:
  - IDLE: moves to BURST when the head entry counter is 0. The head is popped and the beat counter is loaded with N-1.
  - BURST: emits one beat per cycle.
    - On the last beat, if the next head is also due, it stays in BURST with no gap. Otherwise it returns to IDLE.
- Closely spaced issues (spacing < N): the later burst is deferred and starts the cycle after the current burst ends. No error is raised; its counter has already saturated at 0.
- Beat data:
  - dfi_wrdata = wdata; dfi_wrdata_mask = ~wstrb.
  - Underflow: if wdata_valid is low when a beat is needed, the beat still occupies its slot with wrdata 0 and mask all-ones, and err_underflow sets. The missing beat is not re-sent later.
  - Idle cycles: en 0, wrdata 0, mask 0.
- Queue full:
  - cmd_full = (count == CMD_DEPTH).
  - wr_issue while full drops the command and sets err_overflow.
  - Issue and pop in the same cycle while full is accepted: pop first, no error.
- err_clr together with a new error event in the same cycle: set wins.
- busy = queue non-empty OR engine in BURST.

Test Plan:
1. t_wl=3, BL8, single issue at edge 10, wdata_valid always high, beats D0..D3 with wstrb 0xFF -> en high cycles 13–16; wrdata D0,D1,D2,D3; mask 0x00; busy low from 17.
2. t_wl=2, BL4, issues at edges 10 and 12 -> en high 12–15 contiguous; 4 beats in order; no errors.
3. t_wl=2, BL8, issues at edges 10 and 11 -> first burst 12–15, second deferred to 16–19; en continuously high 12–19; no error flags.
4. BL8, wdata_valid low during the 3rd beat only -> that cycle wrdata 0, mask 0xFF; err_underflow 1 until err_clr; remaining beats unshifted.
5. CMD_DEPTH=4, t_wl=15, 5 issues on consecutive edges -> cmd_full high after the 4th; 5th dropped; err_overflow=1; exactly 4 bursts (16 beats) observed.
6. rst asserted during beat 2 of a BL8 burst with 2 entries queued -> all outputs 0 immediately; after release en stays 0 and busy stays 0 with no issues.
